feed_countdown_bcd: RTL and testbench

Loadable MM:SS countdown timer for the feeding interval, with a built-in four-digit display scanner. It counts in packed BCD, pulses `done` when the interval expires to trigger a dispense, and time-multiplexes one BCD nibble at a time onto the seven-segment decoder input (`bcd_digit` → decoder `A`). It also drives the active-low digit anodes. It sits directly upstream of the BCD-to-seven-segment decoder.

---
 rtl/feed_countdown_bcd_if.sv | 25 ++
 rtl/feed_countdown_bcd.sv | 207 ++++++++++++++++++++
 tb/tb_feed_countdown_bcd.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/feed_countdown_bcd_if.sv
// Bus bundle for the feed countdown timer: load/run controls in,
// display scan, status and pulse outputs back out.
interface feed_countdown_bcd_if;
  logic       load;
  logic [7:0] preset_min;
  logic [7:0] preset_sec;
  logic       start;
  logic       pause;
  logic       auto_reload;
  logic [3:0] bcd_digit;
  logic [3:0] an;
  logic       running;
  logic       done;
  logic       load_err;

  modport master (
    output load, preset_min, preset_sec, start, pause, auto_reload,
    input  bcd_digit, an, running, done, load_err
  );

  modport slave (
    input  load, preset_min, preset_sec, start, pause, auto_reload,
    output bcd_digit, an, running, done, load_err
  );
endinterface

// File: rtl/feed_countdown_bcd.sv
// Loadable MM:SS BCD countdown timer for the feeding interval. Pulses done
// on expiry (optionally reloading the preset) and scans the live count onto
// a four-digit multiplexed seven-segment display, one nibble at a time.
module feed_countdown_bcd #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input logic                 clk,
  input logic                 rst,
  feed_countdown_bcd_if.slave bus
);
  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  state_t          state_reg, state_next;
  logic [7:0]      min_reg, min_next;
  logic [7:0]      sec_reg, sec_next;
  logic [7:0]      pmin_reg, pmin_next;
  logic [7:0]      psec_reg, psec_next;
  logic [PW-1:0]   presc_reg, presc_next;
  logic            done_reg, done_next;
  logic            load_err_reg, load_err_next;
  logic            running_reg;

  logic [SW-1:0]   scan_reg, scan_next;
  logic [1:0]      idx_reg, idx_next;
  logic [3:0]      an_reg, an_next;
  logic [3:0]      digit_reg, digit_next;

  logic [7:0]      dec_min, dec_sec;
  logic            load_ok, at_one, count_nz, tick, expire;

  // A preset is accepted only if every nibble is a decimal digit and
  // the seconds tens digit does not exceed 5.
  assign load_ok = (bus.preset_min[7:4] <= 4'd9) && (bus.preset_min[3:0] <= 4'd9) &&
                   (bus.preset_sec[7:4] <= 4'd5) && (bus.preset_sec[3:0] <= 4'd9);
  assign at_one   = (min_reg == 8'h00) && (sec_reg == 8'h01);
  assign count_nz = (min_reg != 8'h00) || (sec_reg != 8'h00);

  // One-second decrement with nibble-wise BCD borrow (units, tens, minutes).
  always_comb begin
    dec_min = min_reg;
    dec_sec = sec_reg;
    if (sec_reg[3:0] != 4'd0) begin
      dec_sec[3:0] = sec_reg[3:0] - 4'd1;
    end else begin
      dec_sec[3:0] = 4'd9;
      if (sec_reg[7:4] != 4'd0) begin
        dec_sec[7:4] = sec_reg[7:4] - 4'd1;
      end else begin
        dec_sec[7:4] = 4'd5;
        if (min_reg[3:0] != 4'd0) begin
          dec_min[3:0] = min_reg[3:0] - 4'd1;
        end else begin
          dec_min[3:0] = 4'd9;
          dec_min[7:4] = min_reg[7:4] - 4'd1;
        end
      end
    end
  end

  // Next-state logic: load first, then prescaler tick / expiry, then start/pause.
  always_comb begin
    state_next    = state_reg;
    min_next      = min_reg;
    sec_next      = sec_reg;
    pmin_next     = pmin_reg;
    psec_next     = psec_reg;
    presc_next    = presc_reg;
    done_next     = 1'b0;
    load_err_next = 1'b0;
    tick          = 1'b0;
    expire        = 1'b0;

    if (bus.load) begin
      // A rejected load consumes the cycle and freezes everything else.
      if (load_ok) begin
        pmin_next  = bus.preset_min;
        psec_next  = bus.preset_sec;
        min_next   = bus.preset_min;
        sec_next   = bus.preset_sec;
        presc_next = '0;
        state_next = IDLE;
      end else begin
        load_err_next = 1'b1;
      end
    end else begin
      if (state_reg == RUN) begin
        if (presc_reg == PRESC_MAX) begin
          tick       = 1'b1;
          presc_next = '0;
        end else begin
          presc_next = presc_reg + PW'(1);
        end
      end

      if (tick) begin
        if (at_one) begin
          expire    = 1'b1;
          done_next = 1'b1;
          if (bus.auto_reload) begin
            min_next = pmin_reg;
            sec_next = psec_reg;
          end else begin
            min_next   = 8'h00;
            sec_next   = 8'h00;
            presc_next = '0;
            state_next = DONE;
          end
        end else begin
          min_next = dec_min;
          sec_next = dec_sec;
        end
      end

      // Expiry overrides a simultaneous pause; start+pause together is a no-op.
      if (!expire && !(bus.start && bus.pause)) begin
        if (bus.start) begin
          case (state_reg)
            IDLE, DONE: if (count_nz) state_next = RUN;
            PAUSED:     state_next = RUN;
            default:    ;
          endcase
        end else if (bus.pause && (state_reg == RUN)) begin
          state_next = PAUSED;
        end
      end
    end
  end

  // Timer control and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      min_reg      <= 8'h00;
      sec_reg      <= 8'h00;
      pmin_reg     <= 8'h00;
      psec_reg     <= 8'h00;
      presc_reg    <= '0;
      done_reg     <= 1'b0;
      load_err_reg <= 1'b0;
      running_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      min_reg      <= min_next;
      sec_reg      <= sec_next;
      pmin_reg     <= pmin_next;
      psec_reg     <= psec_next;
      presc_reg    <= presc_next;
      done_reg     <= done_next;
      load_err_reg <= load_err_next;
      running_reg  <= (state_next == RUN);
    end
  end

  // Free-running scan divider; the digit index advances at each wrap.
  always_comb begin
    scan_next = scan_reg + SW'(1);
    idx_next  = idx_reg;
    if (scan_reg == SCAN_MAX) begin
      scan_next = '0;
      idx_next  = idx_reg + 2'd1;
    end
  end

  // Active-low anode for each slot: low only for the selected digit.
  for (genvar gi = 0; gi < 4; gi++) begin : g_an
    assign an_next[gi] = (idx_next != 2'(gi));
  end

  // Digit mux uses the upcoming count so the display tracks the live value;
  // a zero minutes-tens digit is blanked.
  always_comb begin
    digit_next = 4'h0;
    case (idx_next)
      2'd0:    digit_next = sec_next[3:0];
      2'd1:    digit_next = sec_next[7:4];
      2'd2:    digit_next = min_next[3:0];
      default: digit_next = (min_next[7:4] == 4'd0) ? 4'hF : min_next[7:4];
    endcase
  end

  // Display scan registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_reg  <= '0;
      idx_reg   <= 2'd0;
      an_reg    <= 4'b1110;
      digit_reg <= 4'h0;
    end else begin
      scan_reg  <= scan_next;
      idx_reg   <= idx_next;
      an_reg    <= an_next;
      digit_reg <= digit_next;
    end
  end

  assign bus.an        = an_reg;
  assign bus.bcd_digit = digit_reg;
  assign bus.running   = running_reg;
  assign bus.done      = done_reg;
  assign bus.load_err  = load_err_reg;
endmodule

// File: tb/tb_feed_countdown_bcd.sv
// Randomized and directed bench for feed_countdown_bcd with a scoreboard:
// the driver pushes the reference model's expected outputs per cycle and a
// separate monitor pops and compares them on the falling edge.
module tb_feed_countdown_bcd;
  localparam int CLK_HZ   = 4;
  localparam int SCAN_DIV = 2;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_PAUSED = 2;
  localparam int M_DONE   = 3;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] digit;
    logic       running;
    logic       done;
    logic       load_err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc_no = 0;
  exp_t exp_q[$];

  // Reference model state: count and preset in whole seconds.
  int m_st, m_cnt, m_pre, m_presc, m_k;

  feed_countdown_bcd_if bus ();

  feed_countdown_bcd #(.CLK_HZ(CLK_HZ), .SCAN_DIV(SCAN_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc_no, act, exp_v);
    end
  endtask

  function automatic int to_secs(input logic [7:0] m, input logic [7:0] s);
    return (int'(m[7:4]) * 10 + int'(m[3:0])) * 60 + int'(s[7:4]) * 10 + int'(s[3:0]);
  endfunction

  function automatic exp_t model_out(input logic d, input logic le);
    exp_t e;
    int mm, ss, idx;
    mm  = m_cnt / 60;
    ss  = m_cnt % 60;
    idx = (m_k / SCAN_DIV) % 4;
    e.running  = (m_st == M_RUN);
    e.done     = d;
    e.load_err = le;
    case (idx)
      0: begin e.an = 4'b1110; e.digit = 4'(ss % 10); end
      1: begin e.an = 4'b1101; e.digit = 4'(ss / 10); end
      2: begin e.an = 4'b1011; e.digit = 4'(mm % 10); end
      default: begin e.an = 4'b0111; e.digit = (mm / 10 == 0) ? 4'hF : 4'(mm / 10); end
    endcase
    return e;
  endfunction

  function automatic void model_reset();
    m_st = M_IDLE; m_cnt = 0; m_pre = 0; m_presc = 0; m_k = 0;
  endfunction

  // One clock of timer behaviour expressed on whole seconds.
  function automatic exp_t model_step(input logic ld, input logic [7:0] mi, input logic [7:0] se,
                                      input logic st, input logic pz, input logic ar);
    logic d, le, tick, expired;
    d = 1'b0; le = 1'b0; tick = 1'b0; expired = 1'b0;
    if (ld) begin
      if (mi[7:4] <= 9 && mi[3:0] <= 9 && se[7:4] <= 5 && se[3:0] <= 9) begin
        m_cnt = to_secs(mi, se); m_pre = m_cnt; m_presc = 0; m_st = M_IDLE;
      end else begin
        le = 1'b1;
      end
    end else begin
      if (m_st == M_RUN) begin
        if (m_presc == CLK_HZ - 1) begin tick = 1'b1; m_presc = 0; end
        else m_presc++;
      end
      if (tick) begin
        if (m_cnt == 1) begin
          d = 1'b1; expired = 1'b1;
          if (ar) m_cnt = m_pre;
          else begin m_cnt = 0; m_st = M_DONE; end
        end else begin
          m_cnt--;
        end
      end
      if (!expired && !(st && pz)) begin
        if (st) begin
          if ((m_st == M_IDLE || m_st == M_DONE) && m_cnt != 0) m_st = M_RUN;
          else if (m_st == M_PAUSED) m_st = M_RUN;
        end else if (pz && m_st == M_RUN) begin
          m_st = M_PAUSED;
        end
      end
    end
    m_k++;
    return model_out(d, le);
  endfunction

  task automatic cyc(input logic ld, input logic [7:0] mi, input logic [7:0] se,
                     input logic st, input logic pz, input logic ar);
    bus.load = ld; bus.preset_min = mi; bus.preset_sec = se;
    bus.start = st; bus.pause = pz; bus.auto_reload = ar;
    @(posedge clk);
    #1;
    exp_q.push_back(model_step(ld, mi, se, st, pz, ar));
  endtask

  task automatic idle(input int n, input logic ar);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, ar);
  endtask

  // Asynchronous reset between edges, checked before any clock edge arrives.
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    bus.load = 1'b0; bus.preset_min = 8'h00; bus.preset_sec = 8'h00;
    bus.start = 1'b0; bus.pause = 1'b0; bus.auto_reload = 1'b0;
    #1;
    chk("rst_an", int'(bus.an), 4'b1110);
    chk("rst_digit", int'(bus.bcd_digit), 0);
    chk("rst_running", int'(bus.running), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_load_err", int'(bus.load_err), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Monitor: compare every registered output against the queued expectation.
  always @(negedge clk) begin
    if (!rst && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cyc_no++;
      chk("an", int'(bus.an), int'(e.an));
      chk("bcd_digit", int'(bus.bcd_digit), int'(e.digit));
      chk("running", int'(bus.running), int'(e.running));
      chk("done", int'(bus.done), int'(e.done));
      chk("load_err", int'(bus.load_err), int'(e.load_err));
    end
  end

  initial begin
    logic       ld, st, pz, ar;
    logic [7:0] mi, se;
    int         r;

    model_reset();
    do_reset();
    idle(3, 1'b0);

    // Basic countdown 00:03 to expiry, then start ignored in DONE.
    cyc(1'b1, 8'h00, 8'h03, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    idle(14, 1'b0);
    cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b0);

    // Borrow chains 10:00 -> 09:59 and 01:00 -> 00:59.
    cyc(1'b1, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    idle(12, 1'b0);
    cyc(1'b1, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    idle(12, 1'b0);

    // Invalid loads in IDLE and PAUSED.
    cyc(1'b1, 8'h00, 8'h07, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h00, 8'h60, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h1A, 8'h00, 1'b0, 1'b0, 1'b0);
    idle(4, 1'b0);
    cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    idle(2, 1'b0);
    cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    idle(10, 1'b0);
    cyc(1'b1, 8'hA0, 8'h00, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    idle(6, 1'b0);

    // start+pause together in RUN, then load during RUN.
    for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 8'h00, 8'h45, 1'b0, 1'b0, 1'b0);
    idle(4, 1'b0);

    // Auto-reload from 00:02, several periods.
    cyc(1'b1, 8'h00, 8'h02, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    idle(26, 1'b1);

    // Display of 05:37 with leading-zero blanking, then async reset mid-run.
    cyc(1'b1, 8'h05, 8'h37, 1'b0, 1'b0, 1'b0);
    idle(10, 1'b0);
    cyc(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    idle(9, 1'b0);
    do_reset();
    idle(4, 1'b0);

    // Randomized operation with short presets so expiry happens often.
    ar = 1'b0;
    for (int i = 0; i < 600; i++) begin
      r  = int'($urandom_range(0, 99));
      ld = (r < 4);
      st = ($urandom_range(0, 3) == 0);
      pz = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) ar = ~ar;
      if ($urandom_range(0, 3) == 0) begin
        mi = 8'($urandom_range(0, 255));
        se = 8'($urandom_range(0, 255));
      end else begin
        mi = {4'd0, 4'($urandom_range(0, 1))};
        se = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
      end
      cyc(ld, mi, se, st, pz, ar);
    end

    idle(2, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
